soc_cpu_bridge: RTL



---
 rtl/soc_cpu_bridge_pkg.sv | 20 ++
 rtl/soc_cpu_bridge_tmo.sv | 39 +++
 rtl/soc_cpu_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/soc_cpu_bridge_pkg.sv
// Shared types and constants for the CPU-to-soc_if bridge.
// Holds the FSM state encoding, the default error read data and the error counter width.
package soc_cpu_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS,
        ST_LWR,
        ST_LRD,
        ST_ACK
    } state_e;

    localparam int          ERR_CNT_W     = 16;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/soc_cpu_bridge_tmo.sv
// Wait-cycle counter shared by the BUS and LRD states.
// expire flags the last permitted waiting cycle of an access.
module soc_cpu_bridge_tmo #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int             CW    = $clog2(TIMEOUT_CYC);
    // Compare against the pre-increment value, so the increment taken in the
    // final waiting cycle lands on TIMEOUT_CYC-1.
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/soc_cpu_bridge.sv
// Word-oriented CPU master to soc_if bridge with a local program-memory port.
// One access at a time: capture in IDLE, serve in BUS/LWR/LRD, pulse the ack in ACK.
module soc_cpu_bridge
    import soc_cpu_bridge_pkg::*;
#(
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter int                      REGION_BITS = 4,
    parameter logic [REGION_BITS-1:0]  LOCAL_BASE  = '0,
    parameter int                      TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0]       ERR_RDATA   = DATA_W'(ERR_RDATA_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [DATA_W-1:0]     m_wdat,
    input  logic [DATA_W/8-1:0]   m_be,
    input  logic                  m_we,
    input  logic                  m_rd,
    output logic                  m_wack,
    output logic                  m_rack,
    output logic [DATA_W-1:0]     m_rdat,
    output logic                  m_err,
    output logic                  bus_vld,
    output logic [DATA_W/8-1:0]   bus_we,
    output logic [ADDR_W-3:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdat,
    input  logic                  bus_rdy,
    input  logic [DATA_W-1:0]     bus_rdat,
    output logic [DATA_W/8-1:0]   loc_we,
    output logic                  loc_rd,
    output logic [ADDR_W-1:0]     loc_addr,
    output logic [DATA_W-1:0]     loc_wdat,
    input  logic [DATA_W-1:0]     loc_rdat,
    input  logic                  loc_rvld,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdat_q, wdat_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      rdat_q, rdat_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   lrd_seen_q, lrd_seen_d;

    logic tmo_clr, tmo_en, tmo_exp;
    logic local_hit;

    assign local_hit = (m_addr[ADDR_W-1 -: REGION_BITS] == LOCAL_BASE);

    soc_cpu_bridge_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        be_d       = be_q;
        we_d       = we_q;
        rdat_d     = rdat_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        lrd_seen_d = 1'b0;
        tmo_clr    = 1'b1;
        tmo_en     = 1'b0;
        bus_vld    = 1'b0;
        bus_we     = '0;
        loc_we     = '0;
        loc_rd     = 1'b0;
        m_wack     = 1'b0;
        m_rack     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write wins a simultaneous request; the held m_rd is picked up after ACK.
                if (m_we || m_rd) begin
                    addr_d = m_addr;
                    wdat_d = m_wdat;
                    be_d   = m_be;
                    we_d   = m_we;
                    if (local_hit) begin
                        state_d = m_we ? ST_LWR : ST_LRD;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                bus_vld = 1'b1;
                bus_we  = we_q ? be_q : '0;
                tmo_clr = 1'b0;
                tmo_en  = !bus_rdy;
                if (bus_rdy) begin
                    if (!we_q) rdat_d = bus_rdat;
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (tmo_exp) begin
                    if (!we_q) rdat_d = ERR_RDATA;
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = ST_ACK;
                end
            end

            ST_LWR: begin
                loc_we  = be_q;
                err_d   = 1'b0;
                state_d = ST_ACK;
            end

            ST_LRD: begin
                loc_rd     = !lrd_seen_q;
                lrd_seen_d = 1'b1;
                tmo_clr    = 1'b0;
                tmo_en     = !loc_rvld;
                if (loc_rvld) begin
                    rdat_d  = loc_rdat;
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (tmo_exp) begin
                    rdat_d    = ERR_RDATA;
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = ST_ACK;
                end
            end

            ST_ACK: begin
                m_wack  = we_q;
                m_rack  = !we_q;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdat_q     <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rdat_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            lrd_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rdat_q     <= rdat_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            lrd_seen_q <= lrd_seen_d;
        end
    end

    assign m_rdat   = rdat_q;
    assign m_err    = err_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign bus_addr = addr_q[ADDR_W-1:2];
    assign bus_wdat = wdat_q;
    assign loc_addr = addr_q;
    assign loc_wdat = wdat_q;

endmodule
